apb_node_tmo: RTL and testbench

APB fabric node directly downstream of the AXI-to-APB bridge. Takes the bridge's single APB master port and fans it out to NB_SLAVES peripherals by programmable address ranges. Re-times SETUP/ACCESS toward the slaves and guards every access with a timeout watchdog. Unmapped addresses and hung slaves return PSLVERR upstream, so the bridge never stalls forever.

---
 rtl/apb_node_pkg.sv | 19 +
 rtl/apb_node_addr_dec.sv | 34 +++
 rtl/apb_node_tmo.sv | 155 +++++++++++++++
 tb/tb_apb_node_tmo.sv | 380 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/apb_node_pkg.sv
// Shared types and constants for the APB fan-out node with timeout watchdog.
package apb_node_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2,
        ERR    = 2'd3
    } state_e;

    localparam logic OKAY   = 1'b0;
    localparam logic SLVERR = 1'b1;

    // Width of a binary slave index; a single slave still needs one bit.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/apb_node_addr_dec.sv
// Priority range decoder: slave k hits when start_k <= addr <= end_k; lowest index wins.
module apb_node_addr_dec
    import apb_node_pkg::*;
#(
    parameter int NB_SLAVES      = 4,
    parameter int APB_ADDR_WIDTH = 32,
    parameter int IDX_W          = idx_width(NB_SLAVES)
) (
    input  logic [APB_ADDR_WIDTH-1:0]           addr,
    input  logic [NB_SLAVES*APB_ADDR_WIDTH-1:0] start_addr,
    input  logic [NB_SLAVES*APB_ADDR_WIDTH-1:0] end_addr,
    output logic [NB_SLAVES-1:0]                hit,
    output logic [IDX_W-1:0]                    idx,
    output logic                                miss
);

    // NOTE: every output gets a default before the loop so no path leaves one unassigned (no latch).
    always_comb begin
        hit  = '0;
        idx  = '0;
        miss = 1'b1;
        // Scan downward so the lowest matching index is the last one written.
        for (int k = NB_SLAVES - 1; k >= 0; k--) begin
            if (addr >= start_addr[k*APB_ADDR_WIDTH +: APB_ADDR_WIDTH] &&
                addr <= end_addr[k*APB_ADDR_WIDTH +: APB_ADDR_WIDTH]) begin
                hit    = '0;
                hit[k] = 1'b1;
                idx    = IDX_W'(k);
                miss   = 1'b0;
            end
        end
    end

endmodule

// File: rtl/apb_node_tmo.sv
// APB fan-out node: decodes the upstream access to one of NB_SLAVES, re-times SETUP/ACCESS,
// and aborts hung accesses with SLVERR after TMO_CYCLES ACCESS cycles (0 disables the watchdog).
module apb_node_tmo
    import apb_node_pkg::*;
#(
    parameter int NB_SLAVES      = 4,
    parameter int APB_ADDR_WIDTH = 32,
    parameter int APB_DATA_WIDTH = 32,
    parameter int TMO_CYCLES     = 255,
    parameter int TMO_CNT_WIDTH  = 8
) (
    input  logic                                clk_i,
    input  logic                                rst_ni,
    input  logic [APB_ADDR_WIDTH-1:0]           s_paddr,
    input  logic [APB_DATA_WIDTH-1:0]           s_pwdata,
    input  logic                                s_pwrite,
    input  logic                                s_psel,
    input  logic                                s_penable,
    output logic [APB_DATA_WIDTH-1:0]           s_prdata,
    output logic                                s_pready,
    output logic                                s_pslverr,
    output logic [APB_ADDR_WIDTH-1:0]           m_paddr,
    output logic [APB_DATA_WIDTH-1:0]           m_pwdata,
    output logic                                m_pwrite,
    output logic [NB_SLAVES-1:0]                m_psel,
    output logic                                m_penable,
    input  logic [NB_SLAVES*APB_DATA_WIDTH-1:0] m_prdata,
    input  logic [NB_SLAVES-1:0]                m_pready,
    input  logic [NB_SLAVES-1:0]                m_pslverr,
    input  logic [NB_SLAVES*APB_ADDR_WIDTH-1:0] start_addr_i,
    input  logic [NB_SLAVES*APB_ADDR_WIDTH-1:0] end_addr_i,
    output logic                                tmo_irq_o,
    output logic [TMO_CNT_WIDTH-1:0]            tmo_cnt_o
);

    localparam int             IDX_W   = idx_width(NB_SLAVES);
    localparam int             WD_W    = (TMO_CYCLES > 1) ? $clog2(TMO_CYCLES) : 1;
    localparam bit             TMO_EN  = (TMO_CYCLES > 0);
    localparam logic [WD_W-1:0] WD_LAST = WD_W'((TMO_CYCLES > 0) ? TMO_CYCLES - 1 : 0);

    state_e                    state_q, state_d;
    logic [IDX_W-1:0]          idx_q;
    logic [WD_W-1:0]           wdog_q;
    logic [NB_SLAVES-1:0]      dec_hit;
    logic [IDX_W-1:0]          dec_idx;
    logic                      dec_miss;
    logic                      latch, abort;
    logic                      sel_ready, sel_err;
    logic [APB_DATA_WIDTH-1:0] sel_rdata;

    apb_node_addr_dec #(
        .NB_SLAVES      (NB_SLAVES),
        .APB_ADDR_WIDTH (APB_ADDR_WIDTH),
        .IDX_W          (IDX_W)
    ) u_dec (
        .addr       (s_paddr),
        .start_addr (start_addr_i),
        .end_addr   (end_addr_i),
        .hit        (dec_hit),
        .idx        (dec_idx),
        .miss       (dec_miss)
    );

    always_comb begin
        sel_ready = 1'b0;
        sel_err   = OKAY;
        sel_rdata = '0;
        for (int k = 0; k < NB_SLAVES; k++) begin
            if (idx_q == IDX_W'(k)) begin
                sel_ready = m_pready[k];
                sel_err   = m_pslverr[k];
                sel_rdata = m_prdata[k*APB_DATA_WIDTH +: APB_DATA_WIDTH];
            end
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) state_q <= IDLE;
        else         state_q <= state_d;
    end

    always_comb begin
        state_d   = state_q;
        latch     = 1'b0;
        abort     = 1'b0;
        s_pready  = 1'b0;
        s_pslverr = OKAY;
        s_prdata  = '0;
        unique case (state_q)
            IDLE: begin
                if (s_psel && !s_penable) begin
                    latch   = 1'b1;
                    state_d = dec_miss ? ERR : SETUP;
                end
            end
            SETUP: state_d = ACCESS;
            ACCESS: begin
                s_pready  = sel_ready;
                s_pslverr = sel_err;
                s_prdata  = sel_rdata;
                // A ready slave wins over a watchdog expiring in the same cycle.
                if (sel_ready) begin
                    state_d = IDLE;
                end else if (TMO_EN && wdog_q == WD_LAST) begin
                    abort   = 1'b1;
                    state_d = ERR;
                end
            end
            ERR: begin
                s_pready  = 1'b1;
                s_pslverr = SLVERR;
                state_d   = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            m_paddr   <= '0;
            m_pwdata  <= '0;
            m_pwrite  <= 1'b0;
            m_psel    <= '0;
            m_penable <= 1'b0;
            idx_q     <= '0;
            wdog_q    <= '0;
            tmo_irq_o <= 1'b0;
            tmo_cnt_o <= '0;
        end else begin
            tmo_irq_o <= abort;
            if (latch) begin
                m_paddr  <= s_paddr;
                m_pwdata <= s_pwdata;
                m_pwrite <= s_pwrite;
                idx_q    <= dec_idx;
                m_psel   <= dec_hit;
            end
            if (state_q == SETUP) begin
                m_penable <= 1'b1;
                wdog_q    <= '0;
            end
            if (state_q == ACCESS) begin
                if (sel_ready || abort) begin
                    m_psel    <= '0;
                    m_penable <= 1'b0;
                end else if (TMO_EN) begin
                    wdog_q <= wdog_q + 1'b1;
                end
            end
            if (abort && tmo_cnt_o != '1) tmo_cnt_o <= tmo_cnt_o + 1'b1;
        end
    end

endmodule

// File: tb/tb_apb_node_tmo.sv
// Directed self-checking bench for apb_node_tmo (4 slaves, 8-cycle watchdog, 8-bit abort counter).
module tb_apb_node_tmo;

    localparam int NB  = 4;
    localparam int AW  = 32;
    localparam int DW  = 32;
    localparam int TMO = 8;
    localparam int CW  = 8;

    logic              clk_i = 1'b0;
    logic              rst_ni;
    logic [AW-1:0]     s_paddr;
    logic [DW-1:0]     s_pwdata;
    logic              s_pwrite, s_psel, s_penable;
    logic [DW-1:0]     s_prdata;
    logic              s_pready, s_pslverr;
    logic [AW-1:0]     m_paddr;
    logic [DW-1:0]     m_pwdata;
    logic              m_pwrite;
    logic [NB-1:0]     m_psel;
    logic              m_penable;
    logic [NB*DW-1:0]  m_prdata;
    logic [NB-1:0]     m_pready, m_pslverr;
    logic [NB*AW-1:0]  start_addr_i, end_addr_i;
    logic              tmo_irq_o;
    logic [CW-1:0]     tmo_cnt_o;

    int checks = 0;
    int errors = 0;

    always #5 clk_i = ~clk_i;

    apb_node_tmo #(
        .NB_SLAVES(NB), .APB_ADDR_WIDTH(AW), .APB_DATA_WIDTH(DW),
        .TMO_CYCLES(TMO), .TMO_CNT_WIDTH(CW)
    ) dut (
        .clk_i(clk_i), .rst_ni(rst_ni),
        .s_paddr(s_paddr), .s_pwdata(s_pwdata), .s_pwrite(s_pwrite),
        .s_psel(s_psel), .s_penable(s_penable),
        .s_prdata(s_prdata), .s_pready(s_pready), .s_pslverr(s_pslverr),
        .m_paddr(m_paddr), .m_pwdata(m_pwdata), .m_pwrite(m_pwrite),
        .m_psel(m_psel), .m_penable(m_penable),
        .m_prdata(m_prdata), .m_pready(m_pready), .m_pslverr(m_pslverr),
        .start_addr_i(start_addr_i), .end_addr_i(end_addr_i),
        .tmo_irq_o(tmo_irq_o), .tmo_cnt_o(tmo_cnt_o)
    );

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic set_range(input int k, input logic [AW-1:0] s, input logic [AW-1:0] e);
        start_addr_i[k*AW +: AW] = s;
        end_addr_i[k*AW +: AW]   = e;
    endtask

    task automatic default_ranges();
        set_range(0, 32'h1A10_0000, 32'h1A10_0FFF);
        set_range(1, 32'h1A10_1000, 32'h1A10_1FFF);
        set_range(2, 32'h1A10_2000, 32'h1A10_2FFF);
        set_range(3, 32'h1A10_3000, 32'h1A10_3FFF);
    endtask

    // Bridge-side transfer: SETUP, then ACCESS until s_pready (bounded), then one idle cycle.
    task automatic apb_xfer(input logic [AW-1:0] addr, input logic [DW-1:0] wdata,
                            input logic write, input int budget,
                            output logic [DW-1:0] rdata, output logic err, output int lat,
                            output logic [NB-1:0] psel_or, output int irqs);
        s_paddr = addr; s_pwdata = wdata; s_pwrite = write;
        s_psel = 1'b1; s_penable = 1'b0;
        lat = 0; psel_or = '0; irqs = 0; rdata = '0; err = 1'b0;
        do begin
            tick();
            lat++;
            psel_or |= m_psel;
            irqs += int'(tmo_irq_o);
            s_penable = 1'b1;
        end while (!s_pready && lat < budget);
        if (!s_pready) begin
            checks++; errors++;
            $display("FAIL xfer_bound: no s_pready within %0d cycles for addr %h", budget, addr);
        end else begin
            rdata = s_prdata;
            err   = s_pslverr;
        end
        s_psel = 1'b0; s_penable = 1'b0;
        tick();
        irqs += int'(tmo_irq_o);
    endtask

    task automatic test_reset();
        rst_ni = 1'b0;
        s_paddr = '0; s_pwdata = '0; s_pwrite = 1'b0; s_psel = 1'b0; s_penable = 1'b0;
        m_pready = '1; m_pslverr = '0;
        m_prdata = {32'h3333_3333, 32'h2222_2222, 32'h1111_1111, 32'hDEAD_BEEF};
        default_ranges();
        #3;
        checks++;
        if ({m_psel, m_penable, m_pwrite, s_pready, s_pslverr, tmo_irq_o} !== '0) begin
            errors++;
            $display("FAIL reset_ctrl: psel=%b pen=%b pwr=%b rdy=%b err=%b irq=%b, expected all 0",
                     m_psel, m_penable, m_pwrite, s_pready, s_pslverr, tmo_irq_o);
        end
        checks++;
        if (m_paddr !== '0 || m_pwdata !== '0) begin
            errors++;
            $display("FAIL reset_data: paddr=%h pwdata=%h, expected 0", m_paddr, m_pwdata);
        end
        checks++;
        if (s_prdata !== '0 || tmo_cnt_o !== '0) begin
            errors++;
            $display("FAIL reset_out: prdata=%h cnt=%0d, expected 0", s_prdata, tmo_cnt_o);
        end
        tick(); tick();
        rst_ni = 1'b1;
        tick();
    endtask

    task automatic test_read();
        m_pready = 4'b0001;
        s_paddr = 32'h1A10_0004; s_pwrite = 1'b0; s_psel = 1'b1; s_penable = 1'b0;
        tick();
        checks++;
        if (m_psel !== 4'b0001 || m_penable !== 1'b0 || s_pready !== 1'b0) begin
            errors++;
            $display("FAIL read_setup: psel=%b pen=%b rdy=%b, expected 0001 0 0", m_psel, m_penable, s_pready);
        end
        checks++;
        if (m_paddr !== 32'h1A10_0004 || m_pwrite !== 1'b0) begin
            errors++;
            $display("FAIL read_addr: paddr=%h pwrite=%b, expected 1a100004 0", m_paddr, m_pwrite);
        end
        s_penable = 1'b1;
        tick();
        checks++;
        if (m_psel !== 4'b0001 || m_penable !== 1'b1 || s_pready !== 1'b1 || s_pslverr !== 1'b0) begin
            errors++;
            $display("FAIL read_access_T2: psel=%b pen=%b rdy=%b err=%b, expected 0001 1 1 0",
                     m_psel, m_penable, s_pready, s_pslverr);
        end
        checks++;
        if (s_prdata !== 32'hDEAD_BEEF) begin
            errors++;
            $display("FAIL read_data: got %h expected deadbeef", s_prdata);
        end
        s_psel = 1'b0; s_penable = 1'b0;
        tick();
        checks++;
        if (m_psel !== '0 || m_penable !== 1'b0 || s_pready !== 1'b0 || m_paddr !== 32'h1A10_0004) begin
            errors++;
            $display("FAIL read_idle: psel=%b pen=%b rdy=%b paddr=%h, expected 0000 0 0 1a100004",
                     m_psel, m_penable, s_pready, m_paddr);
        end
    endtask

    task automatic test_write_wait();
        int irqs = 0;
        m_pready = 4'b0000;
        s_paddr = 32'h1A10_1010; s_pwdata = 32'h5A5A_5A5A; s_pwrite = 1'b1;
        s_psel = 1'b1; s_penable = 1'b0;
        tick();
        checks++;
        if (m_psel !== 4'b0010 || m_pwdata !== 32'h5A5A_5A5A || m_pwrite !== 1'b1) begin
            errors++;
            $display("FAIL write_setup: psel=%b pwdata=%h pwrite=%b, expected 0010 5a5a5a5a 1",
                     m_psel, m_pwdata, m_pwrite);
        end
        s_penable = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            irqs += int'(tmo_irq_o);
            checks++;
            if (s_pready !== 1'b0 || m_penable !== 1'b1) begin
                errors++;
                $display("FAIL write_wait%0d: rdy=%b pen=%b, expected 0 1", i, s_pready, m_penable);
            end
        end
        m_pready[1] = 1'b1;
        #1;
        checks++;
        if (s_pready !== 1'b1 || s_pslverr !== 1'b0) begin
            errors++;
            $display("FAIL write_ready: rdy=%b err=%b, expected 1 0", s_pready, s_pslverr);
        end
        s_psel = 1'b0; s_penable = 1'b0;
        tick();
        irqs += int'(tmo_irq_o);
        checks++;
        if (m_psel !== '0 || irqs != 0 || tmo_cnt_o !== 8'd0) begin
            errors++;
            $display("FAIL write_done: psel=%b irqs=%0d cnt=%0d, expected 0000 0 0", m_psel, irqs, tmo_cnt_o);
        end
    endtask

    task automatic test_unmapped();
        logic [DW-1:0] rd; logic er; int lat; logic [NB-1:0] ps; int irqs;
        m_pready = '1;
        apb_xfer(32'h2000_0000, '0, 1'b0, 20, rd, er, lat, ps, irqs);
        checks++;
        if (lat != 1 || er !== 1'b1 || rd !== '0) begin
            errors++;
            $display("FAIL unmapped_err: lat=%0d err=%b rdata=%h, expected 1 1 0", lat, er, rd);
        end
        checks++;
        if (ps !== '0 || irqs != 0) begin
            errors++;
            $display("FAIL unmapped_psel: psel_seen=%b irqs=%0d, expected 0000 0", ps, irqs);
        end
    endtask

    task automatic test_timeout();
        logic [DW-1:0] rd; logic er; int lat; logic [NB-1:0] ps; int irqs;
        m_pready = 4'b1011;
        apb_xfer(32'h1A10_2000, '0, 1'b0, 30, rd, er, lat, ps, irqs);
        checks++;
        if (lat != 10 || er !== 1'b1 || rd !== '0) begin
            errors++;
            $display("FAIL timeout_abort: lat=%0d err=%b rdata=%h, expected 10 1 0", lat, er, rd);
        end
        checks++;
        if (ps !== 4'b0100 || irqs != 1 || tmo_cnt_o !== 8'd1) begin
            errors++;
            $display("FAIL timeout_irq: psel_seen=%b irqs=%0d cnt=%0d, expected 0100 1 1", ps, irqs, tmo_cnt_o);
        end
    endtask

    task automatic test_tmo_vs_pready();
        int bad = 0;
        m_pready = 4'b1011;
        s_paddr = 32'h1A10_2004; s_pwrite = 1'b0; s_psel = 1'b1; s_penable = 1'b0;
        tick();
        s_penable = 1'b1;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (s_pready !== 1'b0 || tmo_irq_o !== 1'b0) bad++;
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL race_wait: %0d early ready/irq samples, expected 0", bad);
        end
        m_pready[2] = 1'b1;
        #1;
        checks++;
        if (s_pready !== 1'b1 || s_pslverr !== 1'b0 || s_prdata !== 32'h2222_2222) begin
            errors++;
            $display("FAIL race_okay: rdy=%b err=%b rdata=%h, expected 1 0 22222222", s_pready, s_pslverr, s_prdata);
        end
        s_psel = 1'b0; s_penable = 1'b0;
        tick();
        checks++;
        if (tmo_irq_o !== 1'b0 || tmo_cnt_o !== 8'd1 || m_psel !== '0 || s_pready !== 1'b0) begin
            errors++;
            $display("FAIL race_after: irq=%b cnt=%0d psel=%b rdy=%b, expected 0 1 0000 0",
                     tmo_irq_o, tmo_cnt_o, m_psel, s_pready);
        end
    endtask

    task automatic test_decode();
        logic [DW-1:0] rd; logic er; int lat; logic [NB-1:0] ps; int irqs;
        m_pready = '1; m_pslverr = 4'b0010;
        apb_xfer(32'h1A10_0FFF, '0, 1'b0, 20, rd, er, lat, ps, irqs);
        checks++;
        if (ps !== 4'b0001 || lat != 2 || er !== 1'b0 || rd !== 32'hDEAD_BEEF) begin
            errors++;
            $display("FAIL dec_end0: psel=%b lat=%0d err=%b rdata=%h, expected 0001 2 0 deadbeef", ps, lat, er, rd);
        end
        apb_xfer(32'h1A10_1000, '0, 1'b0, 20, rd, er, lat, ps, irqs);
        checks++;
        if (ps !== 4'b0010 || er !== 1'b1 || rd !== 32'h1111_1111) begin
            errors++;
            $display("FAIL dec_start1: psel=%b err=%b rdata=%h, expected 0010 1 11111111", ps, er, rd);
        end
        m_pslverr = '0;
        set_range(0, 32'h0000_0000, 32'h0000_0FFF);
        set_range(3, 32'h0000_0100, 32'h0000_01FF);
        apb_xfer(32'h0000_0100, '0, 1'b0, 20, rd, er, lat, ps, irqs);
        checks++;
        if (ps !== 4'b0001 || er !== 1'b0 || rd !== 32'hDEAD_BEEF) begin
            errors++;
            $display("FAIL dec_overlap: psel=%b err=%b rdata=%h, expected 0001 0 deadbeef", ps, er, rd);
        end
        apb_xfer(32'h0000_1000, '0, 1'b0, 20, rd, er, lat, ps, irqs);
        checks++;
        if (ps !== '0 || lat != 1 || er !== 1'b1) begin
            errors++;
            $display("FAIL dec_gap: psel=%b lat=%0d err=%b, expected 0000 1 1", ps, lat, er);
        end
        default_ranges();
    endtask

    task automatic test_tmo_saturate();
        logic [DW-1:0] rd; logic er; int lat; logic [NB-1:0] ps; int irqs;
        int bad = 0;
        m_pready = 4'b1011;
        for (int i = 0; i < 253; i++) begin
            apb_xfer(32'h1A10_2000, '0, 1'b0, 30, rd, er, lat, ps, irqs);
            if (er !== 1'b1 || irqs != 1) bad++;
        end
        checks++;
        if (tmo_cnt_o !== 8'd254) begin
            errors++;
            $display("FAIL sat_254: cnt=%0d expected 254", tmo_cnt_o);
        end
        apb_xfer(32'h1A10_2000, '0, 1'b0, 30, rd, er, lat, ps, irqs);
        if (er !== 1'b1 || irqs != 1) bad++;
        checks++;
        if (tmo_cnt_o !== 8'd255) begin
            errors++;
            $display("FAIL sat_255: cnt=%0d expected 255", tmo_cnt_o);
        end
        for (int i = 0; i < 45; i++) begin
            apb_xfer(32'h1A10_2000, '0, 1'b0, 30, rd, er, lat, ps, irqs);
            if (er !== 1'b1 || irqs != 1) bad++;
        end
        checks++;
        if (tmo_cnt_o !== 8'd255 || bad != 0) begin
            errors++;
            $display("FAIL sat_300: cnt=%0d bad_aborts=%0d, expected 255 0", tmo_cnt_o, bad);
        end
    endtask

    task automatic test_reset_mid_access();
        logic [DW-1:0] rd; logic er; int lat; logic [NB-1:0] ps; int irqs;
        m_pready = 4'b0000;
        s_paddr = 32'h1A10_1000; s_pwrite = 1'b0; s_psel = 1'b1; s_penable = 1'b0;
        tick();
        s_penable = 1'b1;
        tick();
        m_pready[1] = 1'b1;
        #1;
        checks++;
        if (m_psel !== 4'b0010 || m_penable !== 1'b1 || s_pready !== 1'b1) begin
            errors++;
            $display("FAIL rst_pre: psel=%b pen=%b rdy=%b, expected 0010 1 1", m_psel, m_penable, s_pready);
        end
        rst_ni = 1'b0;
        #1;
        checks++;
        if (m_psel !== '0 || m_penable !== 1'b0 || s_pready !== 1'b0 || tmo_cnt_o !== '0) begin
            errors++;
            $display("FAIL rst_async: psel=%b pen=%b rdy=%b cnt=%0d, expected 0000 0 0 0",
                     m_psel, m_penable, s_pready, tmo_cnt_o);
        end
        s_psel = 1'b0; s_penable = 1'b0;
        tick();
        rst_ni = 1'b1;
        tick();
        m_pready = '1;
        apb_xfer(32'h1A10_0004, '0, 1'b0, 20, rd, er, lat, ps, irqs);
        checks++;
        if (ps !== 4'b0001 || lat != 2 || er !== 1'b0 || rd !== 32'hDEAD_BEEF || irqs != 0) begin
            errors++;
            $display("FAIL rst_next: psel=%b lat=%0d err=%b rdata=%h irqs=%0d, expected 0001 2 0 deadbeef 0",
                     ps, lat, er, rd, irqs);
        end
    endtask

    initial begin
        test_reset();
        test_read();
        test_write_wait();
        test_unmapped();
        test_timeout();
        test_tmo_vs_pready();
        test_decode();
        test_tmo_saturate();
        test_reset_mid_access();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
